// File: rtl/licznik_seq_if.sv
// Control/status and counter-side bundle of the mode-counter sequencer.
// The master side issues commands and returns the counter value; the slave is the sequencer.
interface licznik_seq_if #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned LOOP_W = 4,
  parameter int unsigned Q_W    = 4
) ();
  logic              start;
  logic              abort;
  logic [LEN_W-1:0]  up_len;
  logic [LEN_W-1:0]  tog_len;
  logic [LOOP_W-1:0] loops;
  logic [Q_W-1:0]    cnt_q;
  logic              cnt_rst;
  logic              cnt_in;
  logic              busy;
  logic              done;
  logic              aborted;
  logic              err;
  logic [LOOP_W-1:0] loop_cnt;
  logic [Q_W-1:0]    snap_q;

  modport master (
    output start, abort, up_len, tog_len, loops, cnt_q,
    input  cnt_rst, cnt_in, busy, done, aborted, err, loop_cnt, snap_q
  );

  modport slave (
    input  start, abort, up_len, tog_len, loops, cnt_q,
    output cnt_rst, cnt_in, busy, done, aborted, err, loop_cnt, snap_q
  );
endinterface

// File: rtl/licznik_seq.sv
// Sequencer for the 4-bit mode counter: clear, count up, toggle, repeated per loop,
// then snapshot the final counter value. Outputs are decoded from registered state.
module licznik_seq #(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned LOOP_W = 4,
  parameter int unsigned Q_W    = 4
) (
  input logic           clk,
  input logic           rst,
  licznik_seq_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StClr, StUp, StTog, StDone} state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0]  up_len_q, up_len_d;
  logic [LEN_W-1:0]  tog_len_q, tog_len_d;
  logic [LOOP_W-1:0] loops_q, loops_d;
  logic [LEN_W-1:0]  phase_q, phase_d;
  logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d;
  logic [Q_W-1:0]    snap_q, snap_d;
  logic              aborted_q, aborted_d;
  logic              err_q, err_d;

  logic   cfg_bad;
  logic   last_phase;
  logic   last_loop;
  state_e eol_state;

  assign cfg_bad    = (bus.loops == '0) || ((bus.up_len == '0) && (bus.tog_len == '0));
  assign last_phase = (phase_q == LEN_W'(1));
  assign last_loop  = (loop_cnt_q == (loops_q - LOOP_W'(1)));
  assign eol_state  = last_loop ? StDone : StClr;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !cfg_bad) state_d = StClr;
      end
      StClr: begin
        if (bus.abort)              state_d = StIdle;
        else if (up_len_q != '0)    state_d = StUp;
        else                        state_d = StTog;
      end
      StUp: begin
        if (bus.abort)              state_d = StIdle;
        else if (last_phase)        state_d = (tog_len_q != '0) ? StTog : eol_state;
      end
      StTog: begin
        if (bus.abort)              state_d = StIdle;
        else if (last_phase)        state_d = eol_state;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    bus.cnt_rst  = (state_q == StIdle) || (state_q == StClr) || (state_q == StDone);
    bus.cnt_in   = (state_q == StTog);
    bus.busy     = (state_q != StIdle);
    bus.done     = (state_q == StDone);
    bus.aborted  = aborted_q;
    bus.err      = err_q;
    bus.loop_cnt = loop_cnt_q;
    bus.snap_q   = snap_q;
  end

  // Datapath next-state: configuration latch, phase down-counter, loop counter, flags
  always_comb begin
    up_len_d   = up_len_q;
    tog_len_d  = tog_len_q;
    loops_d    = loops_q;
    phase_d    = phase_q;
    loop_cnt_d = loop_cnt_q;
    snap_d     = snap_q;
    aborted_d  = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            up_len_d   = bus.up_len;
            tog_len_d  = bus.tog_len;
            loops_d    = bus.loops;
            loop_cnt_d = '0;
          end
        end
      end
      StClr: begin
        if (bus.abort) aborted_d = 1'b1;
        else           phase_d   = (up_len_q != '0) ? up_len_q : tog_len_q;
      end
      StUp: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
        end else if (!last_phase) begin
          phase_d = phase_q - LEN_W'(1);
        end else if (tog_len_q != '0) begin
          phase_d = tog_len_q;
        end else if (!last_loop) begin
          loop_cnt_d = loop_cnt_q + LOOP_W'(1);
        end
      end
      StTog: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
        end else if (!last_phase) begin
          phase_d = phase_q - LEN_W'(1);
        end else if (!last_loop) begin
          loop_cnt_d = loop_cnt_q + LOOP_W'(1);
        end
      end
      StDone: begin
        snap_d     = bus.cnt_q;
        loop_cnt_d = loops_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_len_q   <= '0;
      tog_len_q  <= '0;
      loops_q    <= '0;
      phase_q    <= '0;
      loop_cnt_q <= '0;
      snap_q     <= '0;
      aborted_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      up_len_q   <= up_len_d;
      tog_len_q  <= tog_len_d;
      loops_q    <= loops_d;
      phase_q    <= phase_d;
      loop_cnt_q <= loop_cnt_d;
      snap_q     <= snap_d;
      aborted_q  <= aborted_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_licznik_seq.sv
// Randomized bench for licznik_seq with an attached mode-counter and a run-level reference model.
module tb_licznik_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   snap_model = 0;

  always #5 clk = ~clk;

  licznik_seq_if #(.LEN_W(8), .LOOP_W(4), .Q_W(4)) bus ();

  licznik_seq #(.LEN_W(8), .LOOP_W(4), .Q_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // The mode counter being sequenced: sync active-high clear, 0 = up, 1 = toggle.
  always_ff @(posedge clk) begin
    if (bus.cnt_rst)     bus.cnt_q <= 4'd0;
    else if (bus.cnt_in) bus.cnt_q <= (bus.cnt_q == 4'd1) ? 4'd4 : 4'd1;
    else                 bus.cnt_q <= bus.cnt_q + 4'd1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Final counter value of one loop: up_len increments from 0, then tog_len toggles.
  function automatic int exp_final(input int up, input int tog);
    int v = up % 16;
    int first;
    int other;
    if (tog == 0) return v;
    first = (v == 1) ? 4 : 1;
    other = (first == 1) ? 4 : 1;
    return (tog % 2 == 1) ? first : other;
  endfunction

  task automatic run(input int up, input int tog, input int lp, input int abort_at);
    int e_rst[$];
    int e_in[$];
    int e_lc[$];
    int n;
    bit bad;
    bad = (lp == 0) || (up == 0 && tog == 0);
    for (int l = 0; l < lp; l++) begin
      e_rst.push_back(1); e_in.push_back(0); e_lc.push_back(l);
      for (int i = 0; i < up; i++) begin
        e_rst.push_back(0); e_in.push_back(0); e_lc.push_back(l);
      end
      for (int i = 0; i < tog; i++) begin
        e_rst.push_back(0); e_in.push_back(1); e_lc.push_back(l);
      end
    end
    e_rst.push_back(1); e_in.push_back(-1); e_lc.push_back(lp - 1);
    n = e_rst.size();

    @(negedge clk);
    bus.up_len  = 8'(up);
    bus.tog_len = 8'(tog);
    bus.loops   = 4'(lp);
    bus.start   = 1'b1;
    bus.abort   = 1'($urandom_range(0, 1));  // ignored in idle
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.up_len  = 8'($urandom);
    bus.tog_len = 8'($urandom);
    bus.loops   = 4'($urandom);

    if (bad) begin
      @(negedge clk);
      check("err_pulse", int'(bus.err), 1);
      check("err_busy", int'(bus.busy), 0);
      @(negedge clk);
      check("err_clear", int'(bus.err), 0);
      check("err_idle", int'(bus.busy), 0);
      return;
    end

    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("busy", int'(bus.busy), 1);
      check("cnt_rst", int'(bus.cnt_rst), e_rst[k]);
      if (e_in[k] >= 0) check("cnt_in", int'(bus.cnt_in), e_in[k]);
      check("loop_cnt", int'(bus.loop_cnt), e_lc[k]);
      check("done", int'(bus.done), (k == n - 1) ? 1 : 0);
      check("aborted_run", int'(bus.aborted), 0);
      bus.start = (k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == abort_at) begin
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_pulse", int'(bus.aborted), 1);
        check("abort_nodone", int'(bus.done), 0);
        check("abort_snap", int'(bus.snap_q), snap_model);
        @(negedge clk);
        check("abort_clear", int'(bus.aborted), 0);
        check("abort_cnt_q", int'(bus.cnt_q), 0);
        return;
      end
    end
    snap_model = exp_final(up, tog);
    @(negedge clk);
    check("end_busy", int'(bus.busy), 0);
    check("end_done", int'(bus.done), 0);
    check("end_loop_cnt", int'(bus.loop_cnt), lp);
    check("end_snap", int'(bus.snap_q), snap_model);
    check("end_cnt_rst", int'(bus.cnt_rst), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int up;
    int tog;
    int lp;
    int total;
    int ab;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.up_len  = '0;
    bus.tog_len = '0;
    bus.loops   = '0;
    repeat (3) @(negedge clk);
    check("rst_cnt_rst", int'(bus.cnt_rst), 1);
    check("rst_cnt_in", int'(bus.cnt_in), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_aborted", int'(bus.aborted), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_loop_cnt", int'(bus.loop_cnt), 0);
    check("rst_snap", int'(bus.snap_q), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run(3, 2, 1, -1);
    run(17, 0, 1, -1);
    run(5, 1, 3, -1);
    run(4, 4, 0, -1);
    run(0, 0, 1, -1);
    run(10, 0, 1, 2);
    run(0, 3, 2, -1);

    for (int it = 0; it < 30; it++) begin
      up    = $urandom_range(0, 20);
      tog   = $urandom_range(0, 6);
      lp    = $urandom_range(0, 4);
      total = lp * (1 + up + tog) + 1;
      ab    = -1;
      if ($urandom_range(0, 3) == 0 && lp > 0 && total > 2) ab = $urandom_range(0, total - 2);
      run(up, tog, lp, ab);
    end

    // Asynchronous reset in the middle of a toggle phase
    @(negedge clk);
    bus.up_len  = 8'd3;
    bus.tog_len = 8'd5;
    bus.loops   = 4'd1;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.cnt_in) found = 1'b1;
    end
    check("reach_tog", int'(found), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_cnt_rst", int'(bus.cnt_rst), 1);
    check("arst_cnt_in", int'(bus.cnt_in), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_loop_cnt", int'(bus.loop_cnt), 0);
    check("arst_snap", int'(bus.snap_q), 0);
    @(negedge clk);
    rst = 1'b1;
    snap_model = 0;
    run(2, 2, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/licznik_seq.md
Name: licznik_seq

Overview:
- Sequencer for the 4-bit mode counter.
- The counter's `in` is the mode select: 0 = count up; 1 = toggle, where a value of 1 goes to 4 and any other value goes to 1. Its `rst` is active-high and synchronous.
- This block drives the counter's `rst` and `in` to run a programmed pattern: clear, count-up for N cycles, toggle for M cycles, repeated L times.
- It snapshots the final counter value and parks the counter at 0 whenever idle.

Parameters:
- LEN_W, 8, width of the up_len and tog_len phase lengths.
- LOOP_W, 4, width of loops and loop_cnt.
- Q_W, 4, counter width; must match the counter instance.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  single-cycle request to begin a run; sampled only in IDLE.
- abort  input  1  cancels a run in CLR, UP or TOG.
- up_len  input  LEN_W  number of count-up cycles per loop; latched at start.
- tog_len  input  LEN_W  number of toggle cycles per loop; latched at start.
- loops  input  LOOP_W  number of loops, 1..15; latched at start.
- cnt_q  input  Q_W  counter output.
- cnt_rst  output  1  drives the counter's rst (active-high).
- cnt_in  output  1  drives the counter's in (0 = up, 1 = toggle).
- busy  output  1  high in CLR, UP, TOG and DONE.
- done  output  1  one-cycle pulse in the DONE state.
- aborted  output  1  one-cycle pulse after an abort.
- err  output  1  one-cycle pulse when start is rejected for a bad configuration.
- loop_cnt  output  LOOP_W  number of loops completed in the current run.
- snap_q  output  Q_W  value of cnt_q captured in DONE.

Behaviour:
- All outputs are registered and decoded from state (Moore). The counter samples them on the following edge.
- Reset (rst=0, asynchronous):
  - state = IDLE, cnt_rst = 1, cnt_in = 0.
  - busy = done = aborted = err = 0.
  - loop_cnt = 0, snap_q = 0.
- States and outputs:
  - IDLE: cnt_rst = 1, cnt_in = 0. The counter is held at 0.
  - CLR: cnt_rst = 1, cnt_in = 0. Lasts one cycle.
  - UP: cnt_rst = 0, cnt_in = 0.
  - TOG: cnt_rst = 0, cnt_in = 1.
  - DONE: cnt_rst = 1, done = 1. Lasts one cycle.
- Transitions out of IDLE:
  - start=1 with loops=0, or with up_len=0 and tog_len=0: err pulses and the block stays in IDLE.
  - start=1 otherwise: latch the configuration, set loop_cnt = 0, go to CLR.
- CLR goes to UP if up_len≠0, otherwise to TOG. The phase down-counter is loaded with the length of the phase being entered.
- UP lasts exactly up_len cycles. It then goes to TOG if tog_len≠0, otherwise to end-of-loop.
- TOG lasts exactly tog_len cycles, then goes to end-of-loop.
- End-of-loop is evaluated on the edge that leaves the last active cycle:
  - If loop_cnt == loops−1, go to DONE.
  - Otherwise loop_cnt increments and the state goes to CLR, so every loop restarts the counter from 0.
- On the edge leaving DONE: snap_q ← cnt_q, loop_cnt ← loops, state → IDLE.
- Latency:
  - start sampled → CLR on the next cycle.
  - Total busy cycles = loops × (1 + up_len + tog_len) + 1.
- Abort:
  - abort=1 in CLR, UP or TOG: go to IDLE on the next edge, with cnt_rst = 1 from that edge and a one-cycle aborted pulse.
  - No done pulse; snap_q is unchanged.
- Ignored inputs and priorities:
  - abort in IDLE or DONE is ignored.
  - start while busy is ignored.
  - start and abort together in IDLE: abort has no effect, start is processed.
- Phase lengths count in LEN_W bits with no wrap. The counter itself wraps modulo 16.
- Input changes on up_len, tog_len or loops during a run have no effect; the values latched at start are used.

Test Plan:
- Reset, then up_len=3, tog_len=2, loops=1, start → cnt_q sequence after CLR is 0,1,2,3,1,4. done pulses once; snap_q=4; busy high for 7 cycles.
- up_len=17, tog_len=0, loops=1 → UP wraps the counter through 15→0; snap_q=1; no cycle with cnt_in=1.
- up_len=5, tog_len=1, loops=3 → cnt_rst is high for one cycle between loops; loop_cnt steps 0,1,2 and reads 3 in IDLE; done pulses once; snap_q=1; busy high for 22 cycles.
- loops=0 with start → err pulses; state stays IDLE. up_len=0, tog_len=0, loops=1 with start → err pulses; no busy.
- abort asserted in the 2nd UP cycle of a run with up_len=10 → IDLE next cycle, aborted pulse, no done, cnt_q=0 one cycle later, snap_q keeps its prior value.
- rst=0 asserted mid-TOG, asynchronously between edges → outputs immediately at their reset values; after release, start performs a fresh run.
